// File: rtl/m_ucode_wloader.sv
// Boot-time microcode loader: packs a byte stream into 48-bit words, writes them
// to consecutive EBR addresses, then verifies a trailing 8-bit checksum.
module m_ucode_wloader #(
  parameter int unsigned NWORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  waddr,
  output logic [47:0] wdata,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [7:0] LAST_ADDR = 8'(NWORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  waddr_q, waddr_d;
  logic [47:0] wdata_q, wdata_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  sum_q,   sum_d;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_COLLECT;
          waddr_d = '0;
          wdata_d = '0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          // Little-endian packing: byte index i lands in wdata[8i+7:8i].
          for (int unsigned i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) wdata_d[8*i +: 8] = in_data;
          end
          sum_d = sum_q + in_data;
          if (idx_q == 3'd5) begin
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_WRITE: begin
        if (waddr_q == LAST_ADDR) begin
          state_d = S_CHECK;
        end else begin
          waddr_d = waddr_q + 8'd1;
          state_d = S_COLLECT;
        end
      end
      S_CHECK: begin
        if (in_valid) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  // Control outputs are pure decodes of the state register, so no input reaches them.
  assign in_ready = (state_q == S_COLLECT) || (state_q == S_CHECK);
  assign we       = (state_q == S_WRITE);
  assign busy     = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_CHECK);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

endmodule
